viterbi_hard_decoder: RTL

//  Hard-decision Viterbi decoder for the rate-1/2, K=3 (g0=7, g1=5 octal) convolutional code of the ConvCode chain.

---
 rtl/conv_code_pkg.sv | 23 ++
 rtl/viterbi_acs.sv | 35 +++
 rtl/viterbi_hard_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/conv_code_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5 octal) convolutional code.
// Used by both the encoder and the hard-decision Viterbi decoder.
package conv_code_pkg;

  localparam int K       = 3;
  localparam int NSTATES = 4;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // state = {u[n-1], u[n-2]}; returns {c0, c1} for input bit u leaving that state
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
    logic [K-1:0] taps;
    taps = {u, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {diff[1] & diff[0], diff[1] ^ diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: picks the cheaper of two incoming
// branches (ties go to predecessor 0) and reports which one won.
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [1:0]      bm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W:0] sum0_s;
  logic [PM_W:0] sum1_s;
  logic [PM_W:0] win_s;

  assign sum0_s = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
  assign sum1_s = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};

  // compare and select the surviving branch
  always_comb begin
    if (sum1_s < sum0_s) begin
      dec_o = 1'b1;
      win_s = sum1_s;
    end else begin
      dec_o = 1'b0;
      win_s = sum0_s;
    end
  end

  // the metric spread of this code keeps sums in range; clamp rather than wrap just in case
  assign pm_o = win_s[PM_W] ? {PM_W{1'b1}} : win_s[PM_W-1:0];

endmodule

// File: rtl/viterbi_hard_decoder.sv
// Hard-decision Viterbi decoder, 4 states, register-exchange survivors,
// one symbol per clock, registered outputs one cycle after the accepting edge.
module viterbi_hard_decoder
  import conv_code_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6,
  parameter int ERR_W    = 16
) (
  input  logic             clk20M_sig,
  input  logic             reset_sig,
  input  logic             sync_clr,
  input  logic             in_valid,
  input  logic [1:0]       in_sym,
  output logic             Dx_oe,
  output logic             decode_sig,
  output logic             error,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]  PM_INIT   = {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [PM_W-1:0]  PM_HALF   = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TB_DEPTH - 1);

  logic [PM_W-1:0]     pm_q      [NSTATES];
  logic [PM_W-1:0]     pm_d      [NSTATES];
  logic [PM_W-1:0]     acs_pm_s  [NSTATES];
  // the oldest survivor bit is only ever consumed as output, so it is never stored
  logic [TB_DEPTH-2:0] sv_q      [NSTATES];
  logic [TB_DEPTH-2:0] sv_d      [NSTATES];
  logic [TB_DEPTH-1:0] sv_ext_s  [NSTATES];
  logic [1:0]          bm_win_s  [NSTATES];
  logic [NSTATES-1:0]  dec_s;
  logic                norm_s;
  logic [1:0]          min_s;

  logic [CNT_W-1:0] fill_q, fill_d;
  logic             dx_oe_q, dx_oe_d;
  logic             dec_bit_q, dec_bit_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  for (genvar g = 0; g < NSTATES; g++) begin : g_state
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};
    localparam logic       U  = NS[1];

    logic [1:0] bm0_s;
    logic [1:0] bm1_s;

    assign bm0_s = hamming2(in_sym, exp_sym(P0, U));
    assign bm1_s = hamming2(in_sym, exp_sym(P1, U));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0_i (pm_q[P0]),
      .bm0_i (bm0_s),
      .pm1_i (pm_q[P1]),
      .bm1_i (bm1_s),
      .pm_o  (acs_pm_s[g]),
      .dec_o (dec_s[g])
    );

    assign bm_win_s[g] = dec_s[g] ? bm1_s : bm0_s;
    assign sv_ext_s[g] = dec_s[g] ? {sv_q[P1], U} : {sv_q[P0], U};
  end

  // normalisation trigger and lowest-index best state
  always_comb begin
    norm_s = 1'b1;
    min_s  = 2'b00;
    for (int i = 0; i < NSTATES; i++) begin
      norm_s = norm_s & acs_pm_s[i][PM_W-1];
      min_s  = (acs_pm_s[i] < acs_pm_s[min_s]) ? 2'(i) : min_s;
    end
  end

  // next-state: frame restart beats a coincident symbol
  always_comb begin
    pm_d      = pm_q;
    sv_d      = sv_q;
    fill_d    = fill_q;
    dx_oe_d   = 1'b0;
    dec_bit_d = dec_bit_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    if (sync_clr) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_d[i] = (i == 0) ? {PM_W{1'b0}} : PM_INIT;
        sv_d[i] = '0;
      end
      fill_d    = '0;
      dec_bit_d = 1'b0;
      err_cnt_d = '0;
    end else if (in_valid) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_d[i] = norm_s ? (acs_pm_s[i] - PM_HALF) : acs_pm_s[i];
        sv_d[i] = sv_ext_s[i][TB_DEPTH-2:0];
      end
      fill_d    = (fill_q == FILL_MAX) ? FILL_MAX : (fill_q + CNT_W'(1));
      dx_oe_d   = (fill_q >= FILL_LAST);
      dec_bit_d = sv_ext_s[min_s][TB_DEPTH-1];
      error_d   = (bm_win_s[min_s] != 2'b00);
      err_cnt_d = (error_d && (err_cnt_q != {ERR_W{1'b1}})) ? (err_cnt_q + ERR_W'(1)) : err_cnt_q;
    end else begin
      dec_bit_d = dec_bit_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk20M_sig or posedge reset_sig) begin
    if (reset_sig) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_q[i] <= (i == 0) ? {PM_W{1'b0}} : PM_INIT;
        sv_q[i] <= '0;
      end
      fill_q    <= '0;
      dx_oe_q   <= 1'b0;
      dec_bit_q <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pm_q      <= pm_d;
      sv_q      <= sv_d;
      fill_q    <= fill_d;
      dx_oe_q   <= dx_oe_d;
      dec_bit_q <= dec_bit_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Dx_oe      = dx_oe_q;
  assign decode_sig = dec_bit_q;
  assign error      = error_q;
  assign err_cnt    = err_cnt_q;

endmodule
